// File: rtl/ireg_ctx_ctrl_pkg.sv
// Shared types for the integer register-file context controller.
package ireg_ctx_ctrl_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_bus_t;
  typedef data_bus_t [XLEN-1:0] ireg_file_t;   // x0..x31
  typedef data_bus_t [XLEN-2:0] ctx_t;         // x1..x31 (x0 is never stored)

  typedef enum logic [2:0] {IDLE, SAVE, RST_RD, RST_WR, ACK} ctx_state_e;
endpackage

// File: rtl/ireg_ctx_ctrl_if.sv
// Trap-unit / register-file side bundle of the context controller.
interface ireg_ctx_ctrl_if import ireg_ctx_ctrl_pkg::*; #(parameter int DEPTH = 4);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          save_req_i;
  logic          restore_req_i;
  logic          ack_o;
  logic          err_o;
  logic          stall_o;
  logic [LW-1:0] level_o;
  ireg_file_t    ireg_file_i;
  ireg_file_t    ireg_file_o;
  logic          rf_sel_all_o;
  logic          rf_we_o;
  logic          rf_clk_en_o;

  modport master (
    output save_req_i, restore_req_i, ireg_file_i,
    input  ack_o, err_o, stall_o, level_o, ireg_file_o,
           rf_sel_all_o, rf_we_o, rf_clk_en_o
  );

  modport slave (
    input  save_req_i, restore_req_i, ireg_file_i,
    output ack_o, err_o, stall_o, level_o, ireg_file_o,
           rf_sel_all_o, rf_we_o, rf_clk_en_o
  );
endinterface

// File: rtl/ireg_ctx_ctrl_stack.sv
// Context storage: DEPTH snapshots of x1..x31, sync write, registered read.
module ireg_ctx_stack import ireg_ctx_ctrl_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  ctx_t                     i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output ctx_t                     o_rdata
);
  ctx_t r_mem [DEPTH];
  ctx_t r_rdata;

  // Contents are don't-care after reset, so no reset on the array or read buffer.
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ireg_ctx_ctrl.sv
// Interrupt entry/return context controller: snapshots x1..x31 into a LIFO and restores them.
module ireg_ctx_ctrl import ireg_ctx_ctrl_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ireg_ctx_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] SP_FULL = LW'(DEPTH);

  ctx_state_e    r_state, w_state_nxt;
  logic [LW-1:0] r_sp, w_sp_dec;
  logic          r_err;
  logic          w_push, w_pop, w_set_err;
  logic          w_ack, w_wr;
  ctx_t          w_rd_data;
  logic          w_unused_x0;

  assign w_sp_dec    = r_sp - LW'(1);
  assign w_unused_x0 = ^bus.ireg_file_i[0];

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Save has priority; a concurrent restore stays pending until the save acks.
        if (bus.save_req_i)         w_state_nxt = SAVE;
        else if (bus.restore_req_i) w_state_nxt = RST_RD;
      end
      SAVE: begin
        if (r_sp == SP_FULL) w_set_err = 1'b1;
        else                 w_push    = 1'b1;
        w_state_nxt = ACK;
      end
      RST_RD: begin
        if (r_sp == '0) begin
          w_set_err   = 1'b1;
          w_state_nxt = ACK;
        end else begin
          w_pop       = 1'b1;
          w_state_nxt = RST_WR;
        end
      end
      RST_WR:  w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sp    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push)     r_sp <= r_sp + LW'(1);
      else if (w_pop) r_sp <= w_sp_dec;
      if (w_set_err)           r_err <= 1'b1;
      else if (r_state == ACK) r_err <= 1'b0;
    end
  end

  ireg_ctx_stack #(.DEPTH(DEPTH)) u_stack (
    .clk_i   (clk_i),
    .i_we    (w_push & ~rst_i),
    .i_waddr (r_sp[AW-1:0]),
    .i_wdata (bus.ireg_file_i[XLEN-1:1]),
    .i_re    (w_pop & ~rst_i),
    .i_raddr (w_sp_dec[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // Reset gates the strobes so an aborted transfer never writes or acks in the reset cycle.
  assign w_ack = (r_state == ACK) & ~rst_i;
  assign w_wr  = (r_state == RST_WR) & ~rst_i;

  assign bus.ack_o        = w_ack;
  assign bus.err_o        = w_ack & r_err;
  assign bus.stall_o      = (r_state != IDLE) | bus.save_req_i | bus.restore_req_i;
  assign bus.level_o      = r_sp;
  assign bus.rf_sel_all_o = w_wr;
  assign bus.rf_we_o      = w_wr;
  assign bus.rf_clk_en_o  = w_wr;

  always_comb begin
    bus.ireg_file_o = '0;
    if (w_wr) bus.ireg_file_o[XLEN-1:1] = w_rd_data;
  end
endmodule

// File: tb/tb_ireg_ctx_ctrl.sv
// Bench for ireg_ctx_ctrl: transaction-level LIFO model plus directed literal pins and random ops.
module tb_ireg_ctx_ctrl;
  import ireg_ctx_ctrl_pkg::*;
  localparam int DEPTH = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;

  ireg_ctx_ctrl_if #(.DEPTH(DEPTH)) bus();
  ireg_ctx_ctrl #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end

  int vecs = 0;
  int errs = 0;

  // reference model: a queue of saved contexts and the cycle schedule of the current transfer
  ireg_file_t stk[$];
  int         acc_cyc = -10, ack_cyc = -10, wr_cyc = -10;
  logic       m_err   = 1'b0;
  ireg_file_t wr_data = '0;
  int         lvl_cur = 0, lvl_pend_cyc = -10, lvl_pend_val = 0;

  // literal expectations posted by the stimulus, consumed by the compare process
  int         req_cyc = 0;
  int         lit_seq = 0, lit_done = 0, lit_lat = 0, lit_lvl = 0;
  logic       lit_err = 1'b0;
  int         litf_seq = 0, litf_done = 0;
  ireg_file_t lit_file = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkf(input string nm, input ireg_file_t act, input ireg_file_t exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    logic e_ack, e_wr, busy;
    ireg_file_t e_file, snap;
    @(negedge clk_i);
    if (cyc == lvl_pend_cyc) lvl_cur = lvl_pend_val;
    e_ack  = (cyc == ack_cyc) && !rst_i;
    e_wr   = (cyc == wr_cyc) && !rst_i;
    e_file = e_wr ? wr_data : '0;
    busy   = (cyc > acc_cyc) && (cyc <= ack_cyc);
    chk("ack",        bus.ack_o,        e_ack);
    chk("err",        bus.err_o,        e_ack && m_err);
    chk("rf_we",      bus.rf_we_o,      e_wr);
    chk("rf_sel_all", bus.rf_sel_all_o, e_wr);
    chk("rf_clk_en",  bus.rf_clk_en_o,  e_wr);
    chkf("ireg_file_o", bus.ireg_file_o, e_file);
    if (!rst_i) begin
      chk("level", bus.level_o, lvl_cur);
      chk("stall", bus.stall_o, busy || bus.save_req_i || bus.restore_req_i);
      if ((bus.save_req_i || bus.restore_req_i) && (cyc - req_cyc) == 9)
        chk("ack_timeout", cyc - req_cyc, 8);
    end
    if (bus.rf_we_o && litf_seq != litf_done) begin
      chkf("lit_restore_data", bus.ireg_file_o, lit_file);
      litf_done = litf_seq;
    end
    if (bus.ack_o && lit_seq != lit_done) begin
      chk("lit_latency", cyc - req_cyc, lit_lat);
      chk("lit_err",     bus.err_o,     lit_err);
      chk("lit_level",   bus.level_o,   lit_lvl);
      lit_done = lit_seq;
    end
    // model step: react to what the DUT sees this cycle
    if (rst_i) begin
      stk.delete();
      acc_cyc = -10; ack_cyc = -10; wr_cyc = -10;
      lvl_pend_cyc = cyc + 1; lvl_pend_val = 0;
    end else if (cyc > ack_cyc && (bus.save_req_i || bus.restore_req_i)) begin
      acc_cyc = cyc;
      if (bus.save_req_i) begin
        ack_cyc = cyc + 2;
        if (stk.size() == DEPTH) m_err = 1'b1;
        else begin
          m_err = 1'b0;
          snap = bus.ireg_file_i;
          snap[0] = '0;
          stk.push_back(snap);
          lvl_pend_cyc = cyc + 2; lvl_pend_val = stk.size();
        end
      end else if (stk.size() == 0) begin
        m_err = 1'b1; ack_cyc = cyc + 2;
      end else begin
        m_err = 1'b0;
        wr_data = stk.pop_back();
        wr_cyc = cyc + 2; ack_cyc = cyc + 3;
        lvl_pend_cyc = cyc + 2; lvl_pend_val = stk.size();
      end
    end
  end

  function automatic ireg_file_t pat(input logic [31:0] base, input bit add_idx, input bit zero_x0);
    ireg_file_t f;
    for (int i = 0; i < XLEN; i++) f[i] = base + (add_idx ? 32'(i) : 32'd0);
    if (zero_x0) f[0] = '0;
    return f;
  endfunction

  task automatic lit(input int lat, input logic e, input int lv);
    lit_lat = lat; lit_err = e; lit_lvl = lv; lit_seq++;
  endtask

  task automatic litf(input ireg_file_t f);
    lit_file = f; litf_seq++;
  endtask

  task automatic op(input bit sv, input bit rs);
    @(posedge clk_i); #1;
    bus.save_req_i = sv; bus.restore_req_i = rs; req_cyc = cyc;
    for (int n = 0; n < 2 && (bus.save_req_i || bus.restore_req_i); n++) begin
      for (int k = 0; k < 12; k++) begin
        @(negedge clk_i);
        if (bus.ack_o) break;
      end
      @(posedge clk_i); #1;
      if (bus.save_req_i) bus.save_req_i = 1'b0;
      else                bus.restore_req_i = 1'b0;
      req_cyc = cyc;
    end
    bus.save_req_i = 1'b0; bus.restore_req_i = 1'b0;
  endtask

  task automatic rst_pulse();
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0;
  endtask

  initial begin
    bus.save_req_i = 1'b0; bus.restore_req_i = 1'b0; bus.ireg_file_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // round trip
    bus.ireg_file_i = pat(32'hA000_0000, 1'b1, 1'b0);
    lit(2, 1'b0, 1); op(1'b1, 1'b0);
    bus.ireg_file_i = pat(32'h5A5A_0000, 1'b1, 1'b0);
    litf(pat(32'hA000_0000, 1'b1, 1'b1)); lit(3, 1'b0, 0); op(1'b0, 1'b1);

    // nesting: 1s, 2s, 3s then LIFO restores
    for (int k = 1; k <= 3; k++) begin
      bus.ireg_file_i = pat(32'h1111_1111 * k, 1'b0, 1'b0);
      lit(2, 1'b0, k); op(1'b1, 1'b0);
    end
    for (int k = 3; k >= 1; k--) begin
      litf(pat(32'h1111_1111 * k, 1'b0, 1'b1)); lit(3, 1'b0, k - 1); op(1'b0, 1'b1);
    end

    // overflow then underflow
    for (int k = 1; k <= 4; k++) begin
      bus.ireg_file_i = pat(32'h1000_0000 * k, 1'b1, 1'b0);
      op(1'b1, 1'b0);
    end
    bus.ireg_file_i = pat(32'hDEAD_0000, 1'b1, 1'b0);
    lit(2, 1'b1, 4); op(1'b1, 1'b0);
    litf(pat(32'h4000_0000, 1'b1, 1'b1)); lit(3, 1'b0, 3); op(1'b0, 1'b1);
    repeat (3) op(1'b0, 1'b1);
    lit(2, 1'b1, 0); op(1'b0, 1'b1);

    // simultaneous requests at level 1: save first, then the held restore pops it
    bus.ireg_file_i = pat(32'h0BAD_0000, 1'b1, 1'b0);
    op(1'b1, 1'b0);
    bus.ireg_file_i = pat(32'hC0DE_0000, 1'b1, 1'b0);
    lit(2, 1'b0, 2); litf(pat(32'hC0DE_0000, 1'b1, 1'b1)); op(1'b1, 1'b1);

    // reset while in RST_RD (level 1)
    @(posedge clk_i); #1; bus.restore_req_i = 1'b1; req_cyc = cyc;
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0; bus.restore_req_i = 1'b0;
    lit(2, 1'b1, 0); op(1'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      for (int i = 0; i < XLEN; i++) bus.ireg_file_i[i] = $urandom;
      if (r < 5)       rst_pulse();
      else if (r < 47) op(1'b1, 1'b0);
      else if (r < 87) op(1'b0, 1'b1);
      else             op(1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
